// File: rtl/moore_seq_pkg.sv
// Shared types and default sizes for the Moore sequence checker.
// MOORE_SEQ_HOLD_ALLOW_EN (see top) changes how a repeated sample is treated.
package moore_seq_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } fsm_t;

   localparam int DEF_STATE_W    = 2;
   localparam int DEF_LOCK_COUNT = 4;
   localparam int DEF_CNT_W      = 8;

   // good_cnt width; covers the full LOCK_COUNT range 1..15
   localparam int GOOD_W = 4;

endpackage

// File: rtl/moore_sequence_checker_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (inc && (cnt_reg != {W{1'b1}})) begin
         cnt_reg <= cnt_reg + W'(1);
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/moore_sequence_checker.sv
// Checks that a sampled state bus steps by +1 (mod 2^STATE_W), locks after a run.
// Define MOORE_SEQ_HOLD_ALLOW_EN to accept a repeated sample as a legal hold.
module moore_sequence_checker
   import moore_seq_pkg::*;
#(
   parameter int STATE_W    = DEF_STATE_W,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [STATE_W-1:0] in_state,
   output logic               locked,
   output logic               err_pulse,
   output logic               cycle_done,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [CNT_W-1:0]   err_count
);

   localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_COUNT);

   fsm_t                state_reg, state_next;
   logic [STATE_W-1:0]  prev_reg, prev_next;
   logic [GOOD_W-1:0]   good_reg, good_next;
   logic                err_reg, err_next;
   logic                done_reg, done_next;

   logic [STATE_W-1:0]  exp_state;
   logic [GOOD_W-1:0]   good_inc;
   logic                match;
   logic                wrap;
   logic                hold;

   assign exp_state = prev_reg + STATE_W'(1);
   assign good_inc  = good_reg + GOOD_W'(1);
   assign match     = (in_state == exp_state);
   assign wrap      = (prev_reg == {STATE_W{1'b1}}) && (in_state == '0);

`ifdef MOORE_SEQ_HOLD_ALLOW_EN
   assign hold = (in_state == prev_reg);
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      prev_next  = prev_reg;
      good_next  = good_reg;
      err_next   = 1'b0;
      done_next  = 1'b0;
      if (in_valid) begin
         prev_next = in_state;
         case (state_reg)
            HUNT: begin
               state_next = SYNC;
               good_next  = '0;
            end
            SYNC: begin
               if (!hold) begin
                  if (match) begin
                     good_next = good_inc;
                     if (good_inc == LOCK_TGT) state_next = LOCKED;
                  end else begin
                     good_next = '0;
                  end
               end
            end
            LOCKED: begin
               // Only samples taken while already locked can report a wrap.
               if (!hold) begin
                  if (match) begin
                     done_next = wrap;
                  end else begin
                     err_next   = 1'b1;
                     state_next = SYNC;
                     good_next  = '0;
                  end
               end
            end
            default: begin
               state_next = HUNT;
               good_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= HUNT;
         prev_reg  <= '0;
         good_reg  <= '0;
         err_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         prev_reg  <= prev_next;
         good_reg  <= good_next;
         err_reg   <= err_next;
         done_reg  <= done_next;
      end
   end

   assign locked     = (state_reg == LOCKED);
   assign err_pulse  = err_reg;
   assign cycle_done = done_reg;

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (done_next),
      .cnt   (cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_next),
      .cnt   (err_count)
   );

endmodule

// File: tb/tb_moore_sequence_checker.sv
// Directed bench for moore_sequence_checker: a default instance and a CNT_W=2 instance
// share one stimulus stream. Expectations follow MOORE_SEQ_HOLD_ALLOW_EN when defined.
module tb_moore_sequence_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_state = 2'd0;

   logic       locked, err_pulse, cycle_done;
   logic [7:0] cycle_count, err_count;
   logic       locked2, err_pulse2, cycle_done2;
   logic [1:0] cycle_count2, err_count2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   moore_sequence_checker dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_state(in_state),
      .locked(locked), .err_pulse(err_pulse), .cycle_done(cycle_done),
      .cycle_count(cycle_count), .err_count(err_count)
   );

   moore_sequence_checker #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_state(in_state),
      .locked(locked2), .err_pulse(err_pulse2), .cycle_done(cycle_done2),
      .cycle_count(cycle_count2), .err_count(err_count2)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_main(input string tag, input logic lk, input logic ep,
                           input logic cd, input logic [7:0] cc, input logic [7:0] ec);
      chk({tag, ".locked"}, {7'd0, locked}, {7'd0, lk});
      chk({tag, ".err_pulse"}, {7'd0, err_pulse}, {7'd0, ep});
      chk({tag, ".cycle_done"}, {7'd0, cycle_done}, {7'd0, cd});
      chk({tag, ".cycle_count"}, cycle_count, cc);
      chk({tag, ".err_count"}, err_count, ec);
   endtask

   // One valid sample; outputs are inspected 1 time unit after the sampling edge.
   task automatic send(input logic [1:0] s);
      @(negedge clk);
      in_valid = 1'b1;
      in_state = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      $display("sample in_state=%0d -> locked=%0b err=%0b done=%0b cc=%0d ec=%0d ec2=%0d",
               s, locked, err_pulse, cycle_done, cycle_count, err_count, err_count2);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_state = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] p;
      logic [1:0] s;
      int         ec_exp;

      // Reset state
      #12;
      chk_main("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("reset.err_count2", {6'd0, err_count2}, 8'd0);
      @(negedge clk);
      reset = 1'b1;

      // Lock on 0,1,2,3,0; the locking 3->0 sample is not a counted wrap
      send(2'd0);
      send(2'd1);
      send(2'd2);
      send(2'd3);
      chk("pre_lock.locked", {7'd0, locked}, 8'd0);
      send(2'd0);
      chk_main("lock", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // One full lap while locked gives one cycle_done
      send(2'd1);
      send(2'd2);
      send(2'd3);
      chk("lap_pre.cycle_done", {7'd0, cycle_done}, 8'd0);
      send(2'd0);
      chk_main("wrap", 1'b1, 1'b0, 1'b1, 8'd1, 8'd0);
      idle(1);
      chk("wrap_after.cycle_done", {7'd0, cycle_done}, 8'd0);

      // Mismatch while locked at prev=1
      send(2'd1);
      send(2'd3);
      chk_main("mismatch", 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
      idle(1);
      chk("mismatch_after.err_pulse", {7'd0, err_pulse}, 8'd0);
      send(2'd0);
      send(2'd1);
      send(2'd2);
      chk("resync_partial.locked", {7'd0, locked}, 8'd0);
      send(2'd3);
      chk_main("relock", 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);

      // Five error/relock rounds with idle gaps; CNT_W=2 instance saturates at 3
      p = 2'd3;
      ec_exp = 1;
      for (int r = 0; r < 5; r++) begin
         s = p + 2'd2;
         send(s);
         ec_exp++;
         chk("round.err_pulse", {7'd0, err_pulse}, 8'd1);
         chk("round.cycle_done", {7'd0, cycle_done}, 8'd0);
         chk("round.err_count", err_count, 8'(ec_exp));
         chk("round.err_count2", {6'd0, err_count2}, (ec_exp > 3) ? 8'd3 : 8'(ec_exp));
         p = s;
         for (int k = 1; k <= 4; k++) begin
            idle(k);
            send(p + 2'(k));
         end
         chk("round.locked", {7'd0, locked}, 8'd1);
         chk("round.err_pulse_clear", {7'd0, err_pulse}, 8'd0);
      end
      chk("rounds.err_count2_sat", {6'd0, err_count2}, 8'd3);
      chk("rounds.cycle_count", cycle_count, 8'd1);

      // Asynchronous reset while locked clears outputs before any clock edge
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_main("async_reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("async_reset.err_count2", {6'd0, err_count2}, 8'd0);
      @(negedge clk);
      reset = 1'b1;
      send(2'd2);
      send(2'd3);
      send(2'd0);
      send(2'd1);
      chk("post_reset.err_pulse", {7'd0, err_pulse}, 8'd0);
      send(2'd2);
      chk_main("post_reset_lock", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // Repeated sample while locked at prev=2
      send(2'd2);
`ifdef MOORE_SEQ_HOLD_ALLOW_EN
      chk_main("repeat", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
`else
      chk_main("repeat", 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/moore_sequence_checker.md
Name: moore_sequence_checker

Overview:
Receive-side companion to the Moore state sequencer. Samples the sequencer's state bus and checks that every new sample is the previous sample +1 mod 2^STATE_W (00→01→10→11→00 for the default width). Acquires lock after a run of correct transitions. While locked, it reports errors, counts completed wraps and counts errors. Sits beside the sequencer as an on-chip monitor or bench checker.

Parameters:
STATE_W, 2, width of the observed state bus.
LOCK_COUNT, 4, consecutive correct transitions needed to lock. Legal range 1..15.
CNT_W, 8, width of cycle_count and err_count. Both counters saturate.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  in_state holds a new sample this cycle.
in_state  input  STATE_W  observed sequencer state.
locked  output  1  Moore output; 1 while the FSM is in LOCKED.
err_pulse  output  1  one-cycle pulse on a mismatch while locked.
cycle_done  output  1  one-cycle pulse on a correct max→0 wrap while locked.
cycle_count  output  CNT_W  number of cycle_done events; saturating.
err_count  output  CNT_W  number of err_pulse events; saturating.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM=HUNT, prev=0, good_cnt=0.
  - All outputs 0.
  - Reset asserted mid-operation clears everything immediately; no pulse is emitted.
- Samples are processed only when in_valid=1. With in_valid=0, all state holds and pulses are 0.
- Every processed sample loads prev, in every FSM state.
- Outputs are registered: response appears the cycle after the sampling edge (latency 1).
- exp = prev+1, truncated to STATE_W bits (natural wrap).
- HUNT: first valid sample loads prev → SYNC, good_cnt=0.
- SYNC:
  - Sample==exp: good_cnt+1. If good_cnt+1==LOCK_COUNT → LOCKED.
  - Sample!=exp: good_cnt=0, stay in SYNC.
  - No err_pulse and no err_count change while in SYNC.
- LOCKED:
  - Sample==exp: stay in LOCKED. If prev=all-ones and sample=0: cycle_done=1, cycle_count+1.
  - Sample!=exp: err_pulse=1, err_count+1, → SYNC, good_cnt=0.
- cycle_done and err_pulse are mutually exclusive.
- cycle_done is never asserted on the sample that causes entry into LOCKED; only samples taken while already in LOCKED count.
- Counters saturate at 2^CNT_W-1 and never wrap.
- An encoding not produced by the sequencer is simply a mismatch.

Optional Feature:
- Macro: MOORE_SEQ_HOLD_ALLOW_EN.
- Defined: a valid sample equal to prev is a legal hold. No error, no good_cnt change, no cycle_done, FSM unchanged.
- Undefined: a repeated value is a mismatch, handled as above.

Decomposition:
- Package moore_seq_pkg:
  - FSM enum typedef {HUNT, SYNC, LOCKED}.
  - Default STATE_W, LOCK_COUNT and CNT_W localparams.
  - Width constant for good_cnt (4 bits).
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output cnt; saturating). Instantiated twice, for cycle_count and err_count.

Test Plan:
- Reset, then valid samples 0,1,2,3,0 → locked=1 one cycle after the 5th sample; cycle_done=0 on that sample; counts stay 0.
- Continue from the first scenario with 1,2,3,0 → one cycle_done pulse after the final 0; cycle_count=1, err_count=0.
- Locked at prev=1, send 3 → err_pulse=1 for one cycle, err_count=1, locked=0. Then 0,1,2,3 → locked=1 again.
- CNT_W=2, five lock/error rounds → err_count reaches 3 and holds at 3. Insert in_valid=0 gaps between samples → no effect on results.
- Locked, assert reset for one cycle mid-stream → all outputs 0 immediately. After release, samples 2,3,0,1,2 → relock with no err_pulse.
- Locked at prev=2, send 2: with MOORE_SEQ_HOLD_ALLOW_EN → no err_pulse, locked stays 1. Without the macro → err_pulse=1, err_count=1.
